// File: rtl/ninja_round_ctrl.sv
// ninja_round_ctrl: round scheduler for the reflex game.
// Alternates GAP/PROMPT phases of HALF_PERIOD cycles, lights one target per
// prompt from an 8-bit LFSR, judges presses and ends the game on round or
// error limits. All outputs are registered alongside the state.
//
// state  | meaning
// IDLE   | waiting for switch=1, counters hold the last game
// GAP    | dark phase, any new press is an early error
// PROMPT | one target lit, first press or timeout ends the phase
// OVER   | game finished, waits for switch=0
module ninja_round_ctrl #(
  parameter int unsigned HALF_PERIOD = 125000000,
  parameter int unsigned MAX_ROUNDS  = 15,
  parameter int unsigned MAX_WRONG   = 3,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       switch,
  input  logic [3:0] btn,
  output logic [3:0] target,
  output logic       phase,
  output logic [3:0] round,
  output logic [3:0] score,
  output logic [2:0] wrong_time,
  output logic       game_over,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GAP    = 2'd1,
    S_PROMPT = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  localparam logic [31:0] HP_LAST = 32'(HALF_PERIOD - 1);
  localparam logic [3:0]  MR      = MAX_ROUNDS[3:0];
  localparam logic [2:0]  MW      = MAX_WRONG[2:0];

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [3:0]  r_btn_q;
  logic [7:0]  r_lfsr;
  logic [3:0]  r_target;
  logic        r_phase;
  logic [3:0]  r_round;
  logic [3:0]  r_score;
  logic [2:0]  r_wrong;
  logic        r_over;
  logic        r_busy;

  logic [3:0]  w_press;
  logic        w_press_any;
  logic        w_hit;
  logic        w_cnt_done;
  logic [2:0]  w_wrong_inc;
  logic        w_wrong_max;
  logic [3:0]  w_round_inc;
  logic        w_round_max;
  logic [3:0]  w_onehot;
  logic [7:0]  w_lfsr_next;

  // Press edges, saturating next-count values and the next LFSR word
  always_comb begin
    w_press     = btn & ~r_btn_q;
    w_press_any = |w_press;
    w_hit       = w_press_any && (w_press == r_target);
    w_cnt_done  = (r_cnt == HP_LAST);
    w_wrong_inc = (r_wrong < MW) ? r_wrong + 3'd1 : r_wrong;
    w_wrong_max = (w_wrong_inc == MW);
    w_round_inc = (r_round < MR) ? r_round + 4'd1 : r_round;
    w_round_max = (w_round_inc == MR);
    w_onehot    = 4'b0001 << r_lfsr[1:0];
    w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  // Game sequencer: state, phase timer, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_btn_q  <= '0;
      r_lfsr   <= LFSR_SEED;
      r_target <= '0;
      r_phase  <= 1'b0;
      r_round  <= '0;
      r_score  <= '0;
      r_wrong  <= '0;
      r_over   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_btn_q <= btn;
      case (r_state)
        S_IDLE: begin
          if (switch) begin
            r_round <= '0;
            r_score <= '0;
            r_wrong <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (!switch) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_press_any && w_wrong_max) begin
            // the early press that reaches the error limit wins over a timeout
            r_wrong <= w_wrong_inc;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_over  <= 1'b1;
            r_state <= S_OVER;
          end else begin
            if (w_press_any) r_wrong <= w_wrong_inc;
            if (w_cnt_done) begin
              r_cnt    <= '0;
              r_target <= w_onehot;
              r_phase  <= 1'b1;
              r_lfsr   <= w_lfsr_next;
              r_state  <= S_PROMPT;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
        end
        S_PROMPT: begin
          if (!switch) begin
            r_cnt    <= '0;
            r_target <= '0;
            r_phase  <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (w_press_any || w_cnt_done) begin
            // a press on the timeout cycle is judged as a press
            r_round  <= w_round_inc;
            r_cnt    <= '0;
            r_target <= '0;
            r_phase  <= 1'b0;
            if (w_hit) r_score <= r_score + 4'd1;
            else       r_wrong <= w_wrong_inc;
            if (w_round_max || (!w_hit && w_wrong_max)) begin
              r_busy  <= 1'b0;
              r_over  <= 1'b1;
              r_state <= S_OVER;
            end else begin
              r_state <= S_GAP;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_OVER: begin
          if (!switch) begin
            r_over  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign target     = r_target;
  assign phase      = r_phase;
  assign round      = r_round;
  assign score      = r_score;
  assign wrong_time = r_wrong;
  assign game_over  = r_over;
  assign busy       = r_busy;

endmodule

// File: doc/ninja_round_ctrl.md
# ninja_round_ctrl

Round scheduler for the reflex game. It sequences alternating gap/prompt phases of a fixed half-period and lights one of four targets per prompt. It judges button presses, counts rounds, score and errors, and ends the game after MAX_ROUNDS prompts or MAX_WRONG errors. It sits between the debounced button inputs and the LED/seven-segment display logic, and replaces free-running phase timing with a run/stop-controlled game sequence.

## Interface
- HALF_PERIOD, 125000000, cycles per gap or prompt phase (2.5 s at 50 MHz); legal values are 2 and up
- MAX_ROUNDS, 15, prompts per game (1..15)
- MAX_WRONG, 3, errors that end the game (1..7)
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- switch  in  1  run level: 1 = play, 0 = stop/abort
- btn  in  4  debounced, synchronous button levels
- target  out  4  one-hot lit target during PROMPT, else 0
- phase  out  1  1 in PROMPT, 0 otherwise
- round  out  4  prompts completed
- score  out  4  correct hits
- wrong_time  out  3  errors, saturates at MAX_WRONG
- game_over  out  1  1 in OVER
- busy  out  1  1 in GAP or PROMPT

## Operation
- Reset: state IDLE, all outputs 0, cnt=0, btn_q=0, lfsr=LFSR_SEED.
- Edge detect: btn_q<=btn every cycle in every state. press = btn & ~btn_q. A button already held on entry never counts.
- IDLE: on switch=1, clear round/score/wrong_time and cnt, then go to GAP. Otherwise hold the counters from the previous game.
- GAP (target=0): any press bit set -> wrong_time+1 (early press). A press does not end the phase. When cnt==HALF_PERIOD-1: cnt<=0, idx<=lfsr[1:0], advance lfsr, go to PROMPT.
- PROMPT (target=onehot(idx)): the phase ends on the first qualifying event.
  - press==target exactly -> score+1 (hit).
  - Any other nonzero press, including target plus extra bits -> wrong_time+1.
  - cnt==HALF_PERIOD-1 with no press -> wrong_time+1 (miss).
  - On every phase end: round+1, cnt<=0.
- After any wrong_time increment, or on leaving PROMPT: if wrong_time==MAX_WRONG or round==MAX_ROUNDS, go to OVER; otherwise PROMPT goes to GAP.
- OVER: target=0, counters frozen, game_over=1. Go to IDLE when switch=0.
- switch=0 in GAP or PROMPT: abort to IDLE next edge, counters held, no scoring that cycle.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. It advances only on GAP->PROMPT.
- cnt is 32-bit. Counter arithmetic never wraps: wrong_time saturates, and round is bounded by MAX_ROUNDS.

## Timing
- All outputs are registered and change on the edge after the triggering condition.
- GAP lasts exactly HALF_PERIOD cycles when uninterrupted. PROMPT lasts HALF_PERIOD cycles on timeout, or ends on the edge after a press.
- Hit latency: btn rises at edge N; press is seen in cycle N; score/round update and the state leaves PROMPT at edge N+1.
- Simultaneous events in PROMPT:
  - A press on the timeout cycle is judged as a press, not a miss.
  - Right and wrong bits together count as wrong.
- A final event that hits both the MAX_WRONG and MAX_ROUNDS limits goes to OVER once; both counters update.
- rst_n low mid-game forces the reset values immediately (asynchronously), regardless of state.
- switch=1 held through OVER keeps OVER; restarting needs switch 0 then 1.

## Test plan
- HALF_PERIOD=8, defaults, reset, switch=1, no presses -> target=4'b0010 for 8 cycles after an 8-cycle gap. Three misses give wrong_time=3, game_over=1, round=3, score=0.
- HALF_PERIOD=8, press the lit target 3 cycles into every prompt -> score increments each prompt. After 15 prompts: round=15, score=15, wrong_time=0, game_over=1.
- Press during GAP twice, then a correct hit -> wrong_time=2, score=1, round=1, busy=1. A third gap press -> OVER with round=1.
- Hold btn[1] high from before start -> no early error counted. Release and press in PROMPT -> hit counted, score=1.
- Press btn=4'b0011 when target=4'b0010 -> wrong_time+1 (not a hit). Press the target on the timeout cycle -> counted as a hit.
- Drop switch mid-PROMPT -> IDLE next edge, target=0, counters held. Assert rst_n=0 mid-GAP -> all outputs 0 immediately, lfsr reseeded, so the first target is again 4'b0010.
